// File: rtl/subtractor_result_fifo_if.sv
// rtl/subtractor_result_fifo_if.sv - handshake bundle between subtractor, result FIFO and consumer
interface subtractor_result_fifo_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sub;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sub;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  modport master (
    output in_valid, in_sub, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_sub, out_zero, out_neg, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_sub, out_zero, out_neg, out_ovf
  );
endinterface

// File: rtl/subtractor_result_fifo.sv
// rtl/subtractor_result_fifo.sv - show-ahead result FIFO with zero/neg/overflow flags captured at write
// Optional push/overflow statistics counters: SUBTRACTOR_RESULT_FIFO_STATS_EN
module subtractor_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  subtractor_result_fifo_if.slave  bus,
  output logic [$clog2(DEPTH):0]   count
`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
  ,
  output logic [31:0]              stat_push_cnt,
  output logic [31:0]              stat_ovf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] sub;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  // Overflow of A-B: operand signs differ and the result sign disagrees with A.
  always_comb begin
    wr_entry      = '0;
    wr_entry.sub  = bus.in_sub;
    wr_entry.zero = (bus.in_sub == '0);
    wr_entry.neg  = bus.in_sub[WIDTH-1];
    wr_entry.ovf  = (bus.in_a_msb != bus.in_b_msb) && (bus.in_sub[WIDTH-1] != bus.in_a_msb);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // Stale storage is hidden while empty so outputs read zero after reset.
  assign head         = mem[rd_ptr];
  assign bus.out_sub  = empty ? '0 : head.sub;
  assign bus.out_zero = empty ? 1'b0 : head.zero;
  assign bus.out_neg  = empty ? 1'b0 : head.neg;
  assign bus.out_ovf  = empty ? 1'b0 : head.ovf;

`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_push_cnt <= '0;
      stat_ovf_cnt  <= '0;
    end else if (push) begin
      stat_push_cnt <= stat_push_cnt + 32'd1;
      if (wr_entry.ovf) begin
        stat_ovf_cnt <= stat_ovf_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_subtractor_result_fifo.sv
// tb/tb_subtractor_result_fifo.sv - directed and randomized bench for subtractor_result_fifo against a queue model
module tb_subtractor_result_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] sub;
    bit          z;
    bit          n;
    bit          o;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [2:0] count;
`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
  logic [31:0] stat_push_cnt;
  logic [31:0] stat_ovf_cnt;
`endif

  subtractor_result_fifo_if #(.WIDTH(WIDTH)) bus ();

  subtractor_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
    ,
    .stat_push_cnt (stat_push_cnt),
    .stat_ovf_cnt  (stat_ovf_cnt)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  ent_t pending;
  int   m_push = 0;
  int   m_ovf  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Overflow from true signed difference, independent of any bit rule.
  function automatic bit arith_ovf(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  function automatic bit msb_ovf(input logic [31:0] s, input bit am, input bit bm);
    return (am != bm) && (s[31] != am);
  endfunction

  task automatic drive(input bit v, input logic [31:0] s, input bit am, input bit bm, input bit ovf_exp);
    bus.in_valid = v;
    bus.in_sub   = s;
    bus.in_a_msb = am;
    bus.in_b_msb = bm;
    pending.sub  = s;
    pending.z    = (s == 32'd0);
    pending.n    = s[31];
    pending.o    = ovf_exp;
  endtask

  task automatic compare(input string where);
    chk({where, ".count"}, 64'(count), 64'(q.size()));
    chk({where, ".in_ready"}, 64'(bus.in_ready), 64'(q.size() != DEPTH));
    chk({where, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk({where, ".out_sub"}, 64'(bus.out_sub), 64'(q[0].sub));
      chk({where, ".out_zero"}, 64'(bus.out_zero), 64'(q[0].z));
      chk({where, ".out_neg"}, 64'(bus.out_neg), 64'(q[0].n));
      chk({where, ".out_ovf"}, 64'(bus.out_ovf), 64'(q[0].o));
    end else begin
      chk({where, ".out_sub_masked"}, 64'(bus.out_sub), 64'd0);
      chk({where, ".flags_masked"}, 64'({bus.out_zero, bus.out_neg, bus.out_ovf}), 64'd0);
    end
`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
    chk({where, ".stat_push"}, 64'(stat_push_cnt), 64'(m_push));
    chk({where, ".stat_ovf"}, 64'(stat_ovf_cnt), 64'(m_ovf));
`endif
  endtask

  task automatic cycle(input string where);
    bit push;
    bit pop;
    push = bus.in_valid && (q.size() < DEPTH);
    pop  = bus.out_ready && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(pending);
      m_push++;
      if (pending.o) m_ovf++;
    end
    #1;
    compare(where);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    clk = 1'b0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    compare("reset");
    rst = 1'b0;

    // Zero result, then pop it
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cycle("zero_push");
    chk("zero_flag", 64'(bus.out_zero), 64'd1);
    drive(1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cycle("zero_pop");
    chk("zero_pop_empty", 64'(bus.out_valid), 64'd0);

    // Positive overflow, then plain negative
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, arith_ovf(32'h8000_0000, 32'h0000_0001));
    cycle("ovf_push");
    chk("ovf_flag", 64'(bus.out_ovf), 64'd1);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, msb_ovf(32'hFFFF_FFFF, 1'b0, 1'b0));
    cycle("neg_push");
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cycle("ovf_pop");
    chk("neg_flag", 64'(bus.out_neg), 64'd1);
    chk("neg_ovf_flag", 64'(bus.out_ovf), 64'd0);
    cycle("neg_pop");

    // Fill to DEPTH, fifth push ignored, drain in order
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      cycle("fill");
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cycle("full_pop_blocks_push");
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle("drain");
    chk("drained", 64'(bus.out_valid), 64'd0);

    // Streaming across pointer wrap
    for (int i = 10; i <= 19; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      cycle("stream");
      chk("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("stream_tail");

    // Randomized traffic with arithmetic-derived flags
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
      s = a - b;
      drive(1'($urandom_range(0, 1)), s, a[31], b[31], arith_ovf(a, b));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      cycle("rand");
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (DEPTH) cycle("rand_drain");

    // Asynchronous reset with three entries held
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0, msb_ovf(32'hA000_0000, 1'b1, 1'b0));
      cycle("pre_reset");
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_push = 0;
    m_ovf  = 0;
    compare("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0);
    cycle("post_reset_push");
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_word", 64'(bus.out_sub), 64'h0000_ABCD);
`ifdef SUBTRACTOR_RESULT_FIFO_STATS_EN
    chk("post_reset_stat_push", 64'(stat_push_cnt), 64'd1);
`endif
    bus.out_ready = 1'b1;
    cycle("post_reset_pop");
    cycle("post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/subtractor_result_fifo.md
Name: subtractor_result_fifo

Overview:
Buffering stage directly downstream of the n-bit ripple subtractor. Captures each combinational difference together with per-result status flags (zero, negative, signed overflow) into a DEPTH-entry FIFO. Decouples the subtractor from the consuming stage with a valid/ready handshake on both sides, so the subtractor's operand source can stall cleanly.

Parameters:
WIDTH, 32, bit width of the difference word; matches the subtractor width.
DEPTH, 4, number of FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream has a difference word on in_sub
in_ready  output  1  FIFO can accept; high when not full
in_sub  input  WIDTH  difference word from the subtractor
in_a_msb  input  1  MSB of the minuend A used to produce in_sub
in_b_msb  input  1  MSB of the subtrahend B used to produce in_sub
out_valid  output  1  head entry is valid; high when not empty
out_ready  input  1  downstream accepts the head entry
out_sub  output  WIDTH  head difference word
out_zero  output  1  head in_sub was all zeros
out_neg  output  1  head in_sub MSB was 1
out_ovf  output  1  head result had a signed two's-complement overflow
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, in_ready=1, out_valid=0. out_sub, out_zero, out_neg and out_ovf read 0. Storage contents are don't-care, but the outputs must be masked to 0 while empty.
- Push: occurs when in_valid && in_ready on a rising edge. The entry stores in_sub, zero=(in_sub==0), neg=in_sub[WIDTH-1], and ovf=(in_a_msb!=in_b_msb) && (in_sub[WIDTH-1]!=in_a_msb). Flags are computed at write time, not read time.
- Pop: occurs when out_valid && out_ready.
- Read side is show-ahead: out_* reflect the head entry combinationally from storage and rd_ptr. No read latency.
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on out_* after edge N.
- No bypass: an empty FIFO never presents in_sub in the same cycle.
- Pointers: log2(DEPTH) bits. Each increments modulo DEPTH and wraps naturally.
- Occupancy: count += push - pop.
- in_ready = (count != DEPTH); out_valid = (count != 0).
- Simultaneous push and pop:
  - Not full, not empty: both occur, count unchanged.
  - Full: push is blocked because in_ready=0, regardless of out_ready. There is no same-cycle pass-through when full.
  - Empty: only the push occurs.
- in_valid while full is ignored with no error. Upstream must hold the data.
- out_ready while empty is ignored.
- Reset mid-operation: all entries are discarded immediately and asynchronously. Outputs return to reset values without waiting for a clock edge.
- Inputs are sampled only on push. Changes to in_sub or in_*_msb while in_ready=0 have no effect.

Optional Feature:
Macro: SUBTRACTOR_RESULT_FIFO_STATS_EN
- Defined: adds output ports stat_push_cnt (32 bits) and stat_ovf_cnt (32 bits).
  - stat_push_cnt increments on each push.
  - stat_ovf_cnt increments on each push whose computed ovf=1.
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0 on rst.
- Undefined: the ports and counters are absent, and the FIFO behaviour is otherwise identical.

Test Plan:
- Reset then idle (WIDTH=32, DEPTH=4) -> in_ready=1, out_valid=0, count=0, out_sub=0.
- Push in_sub=0x00000000 with a_msb=0, b_msb=0; then out_ready=1 -> after 1 edge out_valid=1, out_zero=1, out_neg=0, out_ovf=0; after the pop edge out_valid=0.
- Push in_sub=0x7FFFFFFF with a_msb=1, b_msb=0 (0x80000000-1) -> out_ovf=1, out_neg=0. Then push in_sub=0xFFFFFFFF with a_msb=0, b_msb=0 -> out_neg=1, out_ovf=0.
- Fill: push 4 words 1,2,3,4 with out_ready=0 -> count=4, in_ready=0. A 5th push with value 5 is ignored. Drain -> 1,2,3,4 in order, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles, values 10..19 -> count stays at 1 after the first edge, outputs come out in order across pointer wrap, and no word is lost.
- Reset mid-stream: with count=3, assert rst asynchronously between edges -> count=0 and out_valid=0 immediately. After release, the first new push is the only word output. With SUBTRACTOR_RESULT_FIFO_STATS_EN, stat_push_cnt=1.
